// File: rtl/reg_file.sv
// Integer register file: two combinational read ports, one write port,
// x0 hardwired to zero, write-first bypass and a committed-write counter.
module reg_file #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] rd,
    input  logic [XLEN-1:0]   wdata,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2,
    output logic [15:0]       wr_count
);

    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] regs_d [1:NREG-1];
    logic [15:0]     wr_count_q;
    logic [15:0]     wr_count_d;
    logic            commit;

    // A write is architecturally effective only outside reset and off x0.
    assign commit = rst_n && w_en && (rd != '0);

    always_comb begin
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (commit) begin
            regs_d[rd] = wdata;
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (rs1 != '0) begin
            if (commit && (rd == rs1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs_q[rs1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rs2 != '0) begin
            if (commit && (rd == rs2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs_q[rs2];
            end
        end
    end

    assign wr_count = wr_count_q;

endmodule
